// File: rtl/dot_arb_pkg.sv
// Shared types and the round-robin pick helper for the dot arbiter.
// Widths are sized for the largest supported requester count (8).
package dot_arb_pkg;

   localparam int VEC_LEN    = 3;
   localparam int DATA_WIDTH = 32;
   localparam int N_REQ_MAX  = 8;
   localparam int TAG_W_MAX  = 3;

   typedef logic signed [DATA_WIDTH-1:0] data_t;
   typedef data_t [VEC_LEN-1:0]          vec_t;
   typedef logic [TAG_W_MAX-1:0]         tag_t;

   typedef struct packed {
      logic valid;
      tag_t idx;
   } pick_t;

   // Scan offsets from the highest down so the smallest offset from ptr is the one kept.
   function automatic pick_t rr_pick(input logic [N_REQ_MAX-1:0] eligible,
                                     input tag_t ptr,
                                     input int n);
      pick_t p;
      int    j;
      p = '0;
      for (int off = N_REQ_MAX - 1; off >= 0; off--) begin
         if (off < n) begin
            j = (int'(ptr) + off) % n;
            if (eligible[j[TAG_W_MAX-1:0]]) begin
               p.valid = 1'b1;
               p.idx   = tag_t'(j);
            end
         end
      end
      return p;
   endfunction

endpackage

// File: rtl/dot_arbiter_rr_arbiter.sv
// Round-robin arbiter: grant is the first eligible index at or after rr_ptr.
// rr_ptr moves just past the granted index only when the grant is consumed.
module rr_arbiter
   import dot_arb_pkg::*;
#(
   parameter int N_REQ = 2,
   parameter int TAG_W = 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [N_REQ-1:0] eligible_i,
   input  logic             advance_i,
   output logic [TAG_W-1:0] grant_o,
   output logic             grant_valid_o
);

   logic [TAG_W-1:0]     rr_ptr_q;
   logic [TAG_W-1:0]     rr_ptr_d;
   logic [N_REQ_MAX-1:0] elig_ext;
   pick_t                pick;

   always_comb begin
      elig_ext              = '0;
      elig_ext[N_REQ-1:0]   = eligible_i;
      pick                  = rr_pick(elig_ext, tag_t'(rr_ptr_q), N_REQ);
      grant_o               = pick.idx[TAG_W-1:0];
      grant_valid_o         = pick.valid;
      rr_ptr_d              = (int'(grant_o) == N_REQ - 1) ? '0 : grant_o + TAG_W'(1);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rr_ptr_q <= '0;
      end else if (advance_i) begin
         rr_ptr_q <= rr_ptr_d;
      end
   end

endmodule

// File: rtl/fifo.sv
// First-word-fall-through FIFO: dout_o shows the head whenever empty_o is low.
// Writes while full and reads while empty are dropped.
module fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             wr_en_i,
   input  logic [WIDTH-1:0] din_i,
   input  logic             rd_en_i,
   output logic [WIDTH-1:0] dout_o,
   output logic             empty_o,
   output logic             full_o
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [CW-1:0]    count_q;
   logic             push;
   logic             pop;

   // Explicit wrap so DEPTH need not be a power of two.
   function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
      return (int'(p) == DEPTH - 1) ? '0 : p + AW'(1);
   endfunction

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == CW'(DEPTH));
   assign push    = wr_en_i && !full_o;
   assign pop     = rd_en_i && !empty_o;
   assign dout_o  = mem_q[rd_ptr_q];

   always_ff @(posedge clock) begin
      if (push) begin
         mem_q[wr_ptr_q] <= din_i;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) begin
            wr_ptr_q <= bump(wr_ptr_q);
         end
         if (pop) begin
            rd_ptr_q <= bump(rd_ptr_q);
         end
         case ({push, pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/dot_arbiter.sv
// Shares one dot unit between N_REQ operand streams; each result is steered back
// to its requester's buffer using a tag FIFO, with credits reserving buffer space.
module dot_arbiter
   import dot_arb_pkg::VEC_LEN;
#(
   parameter int N_REQ      = 2,
   parameter int OUT_DEPTH  = 4,
   parameter int DATA_WIDTH = 32
) (
   input  logic                                        clock,
   input  logic                                        reset,
   input  logic [N_REQ-1:0][VEC_LEN-1:0][DATA_WIDTH-1:0] req_x,
   input  logic [N_REQ-1:0][VEC_LEN-1:0][DATA_WIDTH-1:0] req_y,
   input  logic [N_REQ-1:0]                            req_empty,
   output logic [N_REQ-1:0]                            req_rd_en,
   output logic [VEC_LEN-1:0][DATA_WIDTH-1:0]          dot_x,
   output logic [VEC_LEN-1:0][DATA_WIDTH-1:0]          dot_y,
   output logic                                        dot_in_empty,
   input  logic                                        dot_in_rd_en,
   input  logic [DATA_WIDTH-1:0]                       dot_out,
   input  logic                                        dot_out_empty,
   output logic                                        dot_out_rd_en,
   output logic [N_REQ-1:0][DATA_WIDTH-1:0]            res_dout,
   output logic [N_REQ-1:0]                            res_empty,
   input  logic [N_REQ-1:0]                            res_rd_en,
   output logic                                        err_orphan
);

   localparam int TAG_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int CNT_W     = $clog2(OUT_DEPTH) + 1;
   localparam int TAG_DEPTH = N_REQ * OUT_DEPTH;

   logic [N_REQ-1:0][CNT_W-1:0] outstanding_q;
   logic [N_REQ-1:0][CNT_W-1:0] outstanding_d;
   logic                        err_orphan_q;
   logic                        err_orphan_d;

   logic [N_REQ-1:0] eligible;
   logic [N_REQ-1:0] res_pop;
   logic [N_REQ-1:0] res_full;
   logic [TAG_W-1:0] grant;
   logic             grant_valid;
   logic             issue;
   logic             retire;
   logic [TAG_W-1:0] tag_head;
   logic             tag_empty;
   logic             tag_full;

   // Credit covers both the in-flight op and its eventual buffer slot.
   always_comb begin
      for (int i = 0; i < N_REQ; i++) begin
         eligible[i] = !req_empty[i] && (outstanding_q[i] < CNT_W'(OUT_DEPTH)) && !tag_full;
      end
   end

   rr_arbiter #(
      .N_REQ (N_REQ),
      .TAG_W (TAG_W)
   ) u_arb (
      .clock         (clock),
      .reset         (reset),
      .eligible_i    (eligible),
      .advance_i     (issue),
      .grant_o       (grant),
      .grant_valid_o (grant_valid)
   );

   assign issue        = dot_in_rd_en && grant_valid && !reset;
   assign dot_in_empty = !grant_valid;
   assign dot_x        = req_x[grant];
   assign dot_y        = req_y[grant];

   always_comb begin
      for (int i = 0; i < N_REQ; i++) begin
         req_rd_en[i] = issue && (grant == TAG_W'(i));
      end
   end

   fifo #(
      .WIDTH (TAG_W),
      .DEPTH (TAG_DEPTH)
   ) u_tag_fifo (
      .clock   (clock),
      .reset   (reset),
      .wr_en_i (issue),
      .din_i   (grant),
      .rd_en_i (retire),
      .dout_o  (tag_head),
      .empty_o (tag_empty),
      .full_o  (tag_full)
   );

   // A result with no tag is left in dot untouched and only flagged.
   assign retire        = !dot_out_empty && !tag_empty && !res_full[tag_head] && !reset;
   assign dot_out_rd_en = retire;

   for (genvar g = 0; g < N_REQ; g++) begin : g_res
      fifo #(
         .WIDTH (DATA_WIDTH),
         .DEPTH (OUT_DEPTH)
      ) u_res_fifo (
         .clock   (clock),
         .reset   (reset),
         .wr_en_i (retire && (tag_head == TAG_W'(g))),
         .din_i   (dot_out),
         .rd_en_i (res_rd_en[g]),
         .dout_o  (res_dout[g]),
         .empty_o (res_empty[g]),
         .full_o  (res_full[g])
      );
   end

   always_comb begin
      for (int i = 0; i < N_REQ; i++) begin
         res_pop[i] = res_rd_en[i] && !res_empty[i];
         case ({req_rd_en[i], res_pop[i]})
            2'b10:   outstanding_d[i] = outstanding_q[i] + CNT_W'(1);
            2'b01:   outstanding_d[i] = outstanding_q[i] - CNT_W'(1);
            default: outstanding_d[i] = outstanding_q[i];
         endcase
      end
      err_orphan_d = err_orphan_q || (!dot_out_empty && tag_empty);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         outstanding_q <= '0;
         err_orphan_q  <= 1'b0;
      end else begin
         outstanding_q <= outstanding_d;
         err_orphan_q  <= err_orphan_d;
      end
   end

   assign err_orphan = err_orphan_q;

endmodule
